multicycle_control: RTL and testbench

- FSM controller that sequences a multicycle LEGv8 datapath over several clocks. It replaces the single-cycle decoder.
- The datapath has one shared instruction/data memory port with a req/ack handshake, IR/PC/ALUOut/MDR holding registers, and one ALU reused for all operations.
- Supported instructions: ANDREG, ORRREG, ADDREG, SUBREG, ADDIMM, SUBIMM, MOVZ, B, CBZ, LDUR, STUR.
- Also emits a retire pulse and a retired-instruction counter.

---
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle LEGv8 controller and its datapath/memory port.
// The controller drives every select/enable; the datapath returns opcode, zero and mem_ack.
interface multicycle_control_if #(parameter int CNT_W = 32);
  logic [10:0]      opcode;
  logic             zero;
  logic             mem_ack;
  logic             mem_req;
  logic             mem_we;
  logic             iord;
  logic             irwrite;
  logic             mdrwrite;
  logic             pcwrite;
  logic             pcsrc;
  logic             reg2loc;
  logic             alusrc;
  logic             mem2reg;
  logic             regwrite;
  logic [3:0]       aluop;
  logic [2:0]       signop;
  logic             halted;
  logic             retire;
  logic [CNT_W-1:0] retire_count;
  logic [2:0]       state;

  modport master (
    input  opcode, zero, mem_ack,
    output mem_req, mem_we, iord, irwrite, mdrwrite, pcwrite, pcsrc, reg2loc,
           alusrc, mem2reg, regwrite, aluop, signop, halted, retire,
           retire_count, state
  );

  modport slave (
    output opcode, zero, mem_ack,
    input  mem_req, mem_we, iord, irwrite, mdrwrite, pcwrite, pcsrc, reg2loc,
           alusrc, mem2reg, regwrite, aluop, signop, halted, retire,
           retire_count, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 controller: sequences fetch/decode/exec/mem/wb over a shared
// memory port, with a sticky halt on illegal opcodes and a retired-instruction counter.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input logic                 CLK,
  input logic                 Reset,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_LDUR, C_STUR, C_ADDREG, C_ADDIMM, C_SUBREG, C_SUBIMM,
    C_ANDREG, C_ORRREG, C_CBZ, C_B, C_MOVZ, C_ILLEGAL
  } cls_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;

  localparam logic [2:0] EXT_I    = 3'b000;
  localparam logic [2:0] EXT_D    = 3'b001;
  localparam logic [2:0] EXT_B    = 3'b010;
  localparam logic [2:0] EXT_CB   = 3'b011;
  localparam logic [2:0] EXT_MOVZ = 3'b100;

  state_t           state, nxt;
  cls_t             cls, dec;
  logic             halted;
  logic [CNT_W-1:0] cnt;

  logic       mem_req, mem_we, iord, irwrite, mdrwrite, pcwrite, pcsrc;
  logic       reg2loc, alusrc, mem2reg, regwrite, retire, set_halt;
  logic [3:0] aluop;
  logic [2:0] signop;

  // Pattern order matters: first match wins, mirroring the single-cycle decoder.
  always_comb begin
    dec = C_ILLEGAL;
    casez (bus.opcode)
      11'b11111000010: dec = C_LDUR;
      11'b11111000000: dec = C_STUR;
      11'b10001011000: dec = C_ADDREG;
      11'b1001000100?: dec = C_ADDIMM;
      11'b11001011000: dec = C_SUBREG;
      11'b1101000100?: dec = C_SUBIMM;
      11'b10001010000: dec = C_ANDREG;
      11'b10101010000: dec = C_ORRREG;
      11'b10110100???: dec = C_CBZ;
      11'b000101?????: dec = C_B;
      11'b110100101??: dec = C_MOVZ;
      default:         dec = C_ILLEGAL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) state <= S_FETCH;
    else       state <= nxt;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cls    <= C_NONE;
      halted <= 1'b0;
      cnt    <= '0;
    end else begin
      if (state == S_DECODE) cls <= dec;
      if (set_halt)          halted <= 1'b1;
      if (retire)            cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt      = state;
    set_halt = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    mdrwrite = 1'b0;
    pcwrite  = 1'b0;
    pcsrc    = 1'b0;
    reg2loc  = 1'b0;
    alusrc   = 1'b0;
    mem2reg  = 1'b0;
    regwrite = 1'b0;
    retire   = 1'b0;
    aluop    = ALU_AND;
    signop   = EXT_I;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          nxt     = S_DECODE;
        end
      end

      S_DECODE: begin
        reg2loc = (dec == C_STUR) || (dec == C_CBZ);
        case (dec)
          C_B:       nxt = S_BRANCH;
          C_ILLEGAL: begin
            nxt      = S_HALT;
            set_halt = 1'b1;
          end
          default:   nxt = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (cls)
          C_LDUR, C_STUR: begin
            aluop  = ALU_ADD;
            alusrc = 1'b1;
            signop = EXT_D;
            nxt    = S_MEM;
          end
          C_ADDREG: begin aluop = ALU_ADD; nxt = S_WB; end
          C_SUBREG: begin aluop = ALU_SUB; nxt = S_WB; end
          C_ANDREG: begin aluop = ALU_AND; nxt = S_WB; end
          C_ORRREG: begin aluop = ALU_ORR; nxt = S_WB; end
          C_ADDIMM: begin
            aluop  = ALU_ADD;
            alusrc = 1'b1;
            nxt    = S_WB;
          end
          C_SUBIMM: begin
            aluop  = ALU_SUB;
            alusrc = 1'b1;
            nxt    = S_WB;
          end
          C_MOVZ: begin
            aluop  = ALU_PASS;
            alusrc = 1'b1;
            signop = EXT_MOVZ;
            nxt    = S_WB;
          end
          C_CBZ: begin
            // Register operand passes through so the ALU zero flag tests Rt.
            aluop   = ALU_PASS;
            signop  = EXT_CB;
            pcwrite = bus.zero;
            pcsrc   = 1'b1;
            retire  = 1'b1;
            nxt     = S_FETCH;
          end
          default: nxt = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (cls == C_STUR);
        if (bus.mem_ack) begin
          if (cls == C_STUR) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            mdrwrite = 1'b1;
            nxt      = S_WB;
          end
        end
      end

      S_WB: begin
        regwrite = 1'b1;
        mem2reg  = (cls == C_LDUR);
        retire   = 1'b1;
        nxt      = S_FETCH;
      end

      S_BRANCH: begin
        signop  = EXT_B;
        pcwrite = 1'b1;
        pcsrc   = 1'b1;
        retire  = 1'b1;
        nxt     = S_FETCH;
      end

      S_HALT:  nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase
  end

  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.iord         = iord;
  assign bus.irwrite      = irwrite;
  assign bus.mdrwrite     = mdrwrite;
  assign bus.pcwrite      = pcwrite;
  assign bus.pcsrc        = pcsrc;
  assign bus.reg2loc      = reg2loc;
  assign bus.alusrc       = alusrc;
  assign bus.mem2reg      = mem2reg;
  assign bus.regwrite     = regwrite;
  assign bus.aluop        = aluop;
  assign bus.signop       = signop;
  assign bus.halted       = halted;
  assign bus.retire       = retire;
  assign bus.retire_count = cnt;
  assign bus.state        = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a zero-wait instruction table plus
// hand-written wait-state, halt and reset-mid-transaction sequences.
module tb_multicycle_control;
  localparam int CNT_W = 4;

  logic CLK = 1'b0;
  logic Reset;

  multicycle_control_if #(.CNT_W(CNT_W)) bus();
  multicycle_control #(.CNT_W(CNT_W)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  typedef struct {
    string       name;
    logic [10:0] opcode;
    logic        zero;
    logic [2:0]  s2;      // state expected in the third cycle
    logic        r2l;
    logic [3:0]  aluop;
    logic        alusrc;
    logic [2:0]  signop;
    logic        pcw;     // pcwrite expected in the third cycle
    int          cycles;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic bump();
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
  endtask

  // Starts at a negedge with the DUT in FETCH; returns at the negedge it is back in FETCH.
  task automatic run_vec(input vec_t v);
    int cyc;
    int rets;
    cyc  = 0;
    rets = 0;
    bus.opcode  = v.opcode;
    bus.zero    = v.zero;
    bus.mem_ack = 1'b1;
    #1;
    chk({v.name, ".fetch_state"}, 32'(bus.state), 32'd0);
    for (int i = 0; i < 20; i++) begin
      if (i == 1) begin
        chk({v.name, ".decode_state"}, 32'(bus.state), 32'd1);
        chk({v.name, ".reg2loc"}, 32'(bus.reg2loc), 32'(v.r2l));
      end
      if (i == 2) begin
        chk({v.name, ".s2_state"}, 32'(bus.state), 32'(v.s2));
        chk({v.name, ".pcwrite"}, 32'(bus.pcwrite), 32'(v.pcw));
        chk({v.name, ".signop"}, 32'(bus.signop), 32'(v.signop));
        if (v.s2 == 3'd5) chk({v.name, ".pcsrc"}, 32'(bus.pcsrc), 32'd1);
        else begin
          chk({v.name, ".aluop"}, 32'(bus.aluop), 32'(v.aluop));
          chk({v.name, ".alusrc"}, 32'(bus.alusrc), 32'(v.alusrc));
        end
      end
      if (bus.retire) rets++;
      cyc++;
      @(negedge CLK);
      if (bus.state == 3'd0) break;
    end
    bump();
    chk({v.name, ".cycles"}, 32'(cyc), 32'(v.cycles));
    chk({v.name, ".retire_pulses"}, 32'(rets), 32'd1);
    chk({v.name, ".retire_count"}, 32'(bus.retire_count), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{"ADDREG", 11'b10001011000, 1'b0, 3'd2, 1'b0, 4'b0010, 1'b0, 3'b000, 1'b0, 4};
    tbl[1]  = '{"SUBREG", 11'b11001011000, 1'b0, 3'd2, 1'b0, 4'b0110, 1'b0, 3'b000, 1'b0, 4};
    tbl[2]  = '{"ANDREG", 11'b10001010000, 1'b0, 3'd2, 1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 4};
    tbl[3]  = '{"ORRREG", 11'b10101010000, 1'b0, 3'd2, 1'b0, 4'b0001, 1'b0, 3'b000, 1'b0, 4};
    tbl[4]  = '{"ADDIMM", 11'b10010001001, 1'b0, 3'd2, 1'b0, 4'b0010, 1'b1, 3'b000, 1'b0, 4};
    tbl[5]  = '{"SUBIMM", 11'b11010001000, 1'b0, 3'd2, 1'b0, 4'b0110, 1'b1, 3'b000, 1'b0, 4};
    tbl[6]  = '{"MOVZ",   11'b11010010101, 1'b0, 3'd2, 1'b0, 4'b0111, 1'b1, 3'b100, 1'b0, 4};
    tbl[7]  = '{"LDUR",   11'b11111000010, 1'b0, 3'd2, 1'b0, 4'b0010, 1'b1, 3'b001, 1'b0, 5};
    tbl[8]  = '{"STUR",   11'b11111000000, 1'b0, 3'd2, 1'b1, 4'b0010, 1'b1, 3'b001, 1'b0, 4};
    tbl[9]  = '{"CBZ_Z1", 11'b10110100101, 1'b1, 3'd2, 1'b1, 4'b0111, 1'b0, 3'b011, 1'b1, 3};
    tbl[10] = '{"CBZ_Z0", 11'b10110100010, 1'b0, 3'd2, 1'b1, 4'b0111, 1'b0, 3'b011, 1'b0, 3};
    tbl[11] = '{"B",      11'b00010100111, 1'b0, 3'd5, 1'b0, 4'b0000, 1'b0, 3'b010, 1'b1, 3};

    Reset = 1'b1;
    bus.opcode = 11'b0;
    bus.zero = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk("reset.state", 32'(bus.state), 32'd0);
    chk("reset.halted", 32'(bus.halted), 32'd0);
    chk("reset.retire_count", 32'(bus.retire_count), 32'd0);
    chk("reset.fetch_mem_req", 32'(bus.mem_req), 32'd1);

    // Two passes so the 4-bit counter wraps.
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 12; k++) run_vec(tbl[k]);

    // LDUR: fetch ack after 2 wait cycles, MEM ack after 3.
    bus.opcode = 11'b11111000010;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ack = (i == 2);
      #1;
      chk("ldw.fetch_state", 32'(bus.state), 32'd0);
      chk("ldw.fetch_req", 32'(bus.mem_req), 32'd1);
      chk("ldw.irwrite", 32'(bus.irwrite), 32'(i == 2));
      @(negedge CLK);
    end
    bus.mem_ack = 1'b0;
    #1;
    chk("ldw.decode", 32'(bus.state), 32'd1);
    @(negedge CLK);
    chk("ldw.exec", 32'(bus.state), 32'd2);
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack = (i == 3);
      #1;
      chk("ldw.mem_state", 32'(bus.state), 32'd3);
      chk("ldw.mem_req_iord_we", {29'd0, bus.mem_req, bus.iord, bus.mem_we}, 32'b110);
      chk("ldw.mdrwrite", 32'(bus.mdrwrite), 32'(i == 3));
      @(negedge CLK);
    end
    bus.mem_ack = 1'b0;
    #1;
    chk("ldw.wb_state", 32'(bus.state), 32'd4);
    chk("ldw.wb_mem2reg_regwrite_retire", {29'd0, bus.mem2reg, bus.regwrite, bus.retire}, 32'b111);
    @(negedge CLK);
    bump();
    chk("ldw.back_to_fetch", 32'(bus.state), 32'd0);
    chk("ldw.retire_count", 32'(bus.retire_count), 32'(exp_cnt));

    // Illegal opcode: sticky halt ignores memory acks until reset.
    bus.opcode = 11'b0;
    bus.mem_ack = 1'b1;
    @(negedge CLK);
    chk("ill.decode", 32'(bus.state), 32'd1);
    @(negedge CLK);
    chk("ill.halt_state", 32'(bus.state), 32'd6);
    chk("ill.halted", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("ill.no_mem_req", 32'(bus.mem_req), 32'd0);
      chk("ill.no_retire", 32'(bus.retire), 32'd0);
      @(negedge CLK);
      chk("ill.stays_halt", 32'(bus.state), 32'd6);
    end
    chk("ill.count_unchanged", 32'(bus.retire_count), 32'(exp_cnt));
    Reset = 1'b1;
    bus.mem_ack = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    exp_cnt = 0;
    #1;
    chk("ill.reset_state", 32'(bus.state), 32'd0);
    chk("ill.reset_halted", 32'(bus.halted), 32'd0);

    // Reset while a STUR sits in its MEM wait.
    bus.opcode = 11'b11111000000;
    bus.mem_ack = 1'b1;
    @(negedge CLK);
    bus.mem_ack = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("strst.mem_state", 32'(bus.state), 32'd3);
    chk("strst.mem_we", 32'(bus.mem_we), 32'd1);
    Reset = 1'b1;
    @(negedge CLK);
    bus.mem_ack = 1'b1;
    #1;
    chk("strst.state", 32'(bus.state), 32'd0);
    chk("strst.mem_we", 32'(bus.mem_we), 32'd0);
    chk("strst.retire", 32'(bus.retire), 32'd0);
    chk("strst.regwrite", 32'(bus.regwrite), 32'd0);
    chk("strst.retire_count", 32'(bus.retire_count), 32'd0);
    @(negedge CLK);
    chk("strst.state_held", 32'(bus.state), 32'd0);
    chk("strst.count_held", 32'(bus.retire_count), 32'd0);
    Reset = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge CLK);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
